// File: rtl/sprite_line_renderer_pkg.sv
// Shared constants, FSM encoding and helpers for the sprite renderer.
// The pixel counter uses the same H_ACTIVE.
package sprite_line_renderer_pkg;

  localparam int COLOR_W  = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [COLOR_W-1:0] TRANSP_KEY = 12'hF0F;

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'b00,
    S_ABOVE      = 2'b01,
    S_ROWS       = 2'b10,
    S_BELOW      = 2'b11
  } state_t;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational sprite bounds check and texel address generation.
// Reused for multi-sprite and collision logic.
module sprite_hit_test #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int ADDR_W   = 10
) (
  input  logic [9:0]        i_h,
  input  logic [9:0]        i_v,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_en,
  output logic              o_inside,
  output logic              o_v_reached,
  output logic              o_v_past,
  output logic [ADDR_W-1:0] o_addr
);
  import sprite_line_renderer_pkg::*;

  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = ADDR_W - XB;

  logic [10:0]   w_h;
  logic [10:0]   w_v;
  logic [10:0]   w_x;
  logic [10:0]   w_y;
  logic [10:0]   w_xe;
  logic [10:0]   w_ye;
  logic          w_h_in;
  logic [XB-1:0] w_dx;
  logic [YB-1:0] w_dy;

  // 11-bit sums keep right/bottom edges from wrapping
  assign w_h  = ext11(i_h);
  assign w_v  = ext11(i_v);
  assign w_x  = ext11(i_x);
  assign w_y  = ext11(i_y);
  assign w_xe = w_x + 11'(SPRITE_W);
  assign w_ye = w_y + 11'(SPRITE_H);

  assign w_h_in      = (w_h >= w_x) & (w_h < w_xe);
  assign o_v_reached = (w_v >= w_y);
  assign o_v_past    = (w_v >= w_ye);
  assign o_inside    = i_en & w_h_in & o_v_reached & ~o_v_past;

  assign w_dx   = XB'(i_h - i_x);
  assign w_dy   = YB'(i_v - i_y);
  assign o_addr = {w_dy, w_dx};

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-pixel single-sprite overlay: frame-latched position, ROM fetch,
// transparency key, two-clock pixel pipeline.
module sprite_line_renderer #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int COLOR_W  = sprite_line_renderer_pkg::COLOR_W,
  parameter int ADDR_W   = 10,
  parameter logic [COLOR_W-1:0] TRANSP_KEY =
    sprite_line_renderer_pkg::TRANSP_KEY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixel_clk,
  input  logic [9:0]         H_pos_in,
  input  logic               active_finder_position,
  input  logic [9:0]         V_pos_in,
  input  logic               frame_start,
  input  logic [9:0]         sprite_x_in,
  input  logic [9:0]         sprite_y_in,
  input  logic               sprite_en_in,
  input  logic [COLOR_W-1:0] bg_rgb,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               rgb_valid,
  output logic               sprite_hit
);
  import sprite_line_renderer_pkg::*;

  state_t             r_state;
  logic [9:0]         r_sx;
  logic [9:0]         r_sy;
  logic               r_sen;
  logic               r_v1;
  logic               r_in1;
  logic [COLOR_W-1:0] r_bg1;

  logic              w_qual;
  logic              w_box;
  logic              w_v_reached;
  logic              w_v_past;
  logic              w_rows;
  logic              w_inside;
  logic              w_opaque;
  logic [ADDR_W-1:0] w_addr;

  sprite_hit_test #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .ADDR_W  (ADDR_W)
  ) u_hit (
    .i_h        (H_pos_in),
    .i_v        (V_pos_in),
    .i_x        (r_sx),
    .i_y        (r_sy),
    .i_en       (r_sen),
    .o_inside   (w_box),
    .o_v_reached(w_v_reached),
    .o_v_past   (w_v_past),
    .o_addr     (w_addr)
  );

  assign w_qual = pixel_clk & active_finder_position;

  // The strobe that moves ABOVE->ROWS is itself on the sprite's first row
  assign w_rows = (r_state == S_ROWS) |
                  ((r_state == S_ABOVE) & w_v_reached & r_sen);

  assign w_inside = w_qual & w_box & w_rows;
  assign w_opaque = r_in1 & (rom_data != TRANSP_KEY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_WAIT_FRAME;
      r_sx    <= '0;
      r_sy    <= '0;
      r_sen   <= 1'b0;
    end else if (frame_start) begin
      r_state <= S_ABOVE;
      r_sx    <= sprite_x_in;
      r_sy    <= sprite_y_in;
      r_sen   <= sprite_en_in;
    end else if (w_qual) begin
      unique case (r_state)
        S_ABOVE: if (w_v_reached & r_sen) r_state <= S_ROWS;
        S_ROWS:  if (w_v_past) r_state <= S_BELOW;
        default: r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1       <= 1'b0;
      r_in1      <= 1'b0;
      r_bg1      <= '0;
      rom_addr   <= '0;
      rgb_out    <= '0;
      rgb_valid  <= 1'b0;
      sprite_hit <= 1'b0;
    end else begin
      r_v1      <= w_qual;
      r_in1     <= w_inside;
      rgb_valid <= r_v1;
      if (w_qual) r_bg1 <= bg_rgb;
      if (w_inside) rom_addr <= w_addr;
      if (r_v1) begin
        rgb_out    <= w_opaque ? rom_data : r_bg1;
        sprite_hit <= w_opaque;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer: directed literal checks plus
// randomized raster sweeps against a rectangle-and-ROM model.
module tb_sprite_line_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pixel_clk = 1'b0;
  logic        active = 1'b0;
  logic        frame_start = 1'b0;
  logic        sprite_en_in = 1'b0;
  logic [9:0]  H = '0;
  logic [9:0]  V = '0;
  logic [9:0]  sxi = '0;
  logic [9:0]  syi = '0;
  logic [11:0] bg = '0;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  logic        sprite_hit;

  logic [11:0] rom [1024];
  assign rom_data = rom[rom_addr];

  sprite_line_renderer dut (
    .clk                   (clk),
    .rst                   (rst),
    .pixel_clk             (pixel_clk),
    .H_pos_in              (H),
    .active_finder_position(active),
    .V_pos_in              (V),
    .frame_start           (frame_start),
    .sprite_x_in           (sxi),
    .sprite_y_in           (syi),
    .sprite_en_in          (sprite_en_in),
    .bg_rgb                (bg),
    .rom_addr              (rom_addr),
    .rom_data              (rom_data),
    .rgb_out               (rgb_out),
    .rgb_valid             (rgb_valid),
    .sprite_hit            (sprite_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          ev  [64];
  logic [11:0] erg [64];
  bit          eh  [64];
  bit          eav [64];
  logic [9:0]  ea  [64];

  int m_sx, m_sy;
  bit m_sen, m_framed;

  int vectors = 0;
  int miscompares = 0;
  int hit_cnt = 0;
  int cidx;
  int h0;
  logic [11:0] last_rgb = '0;
  bit          last_hit = 1'b0;
  logic [9:0]  last_addr = '0;

  int rx, ry, rv, rhs;
  bit ren;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cidx = cyc % 64;
      chk("rgb_valid", int'(rgb_valid), int'(ev[cidx]));
      if (ev[cidx]) begin
        last_rgb = erg[cidx];
        last_hit = eh[cidx];
      end
      chk("rgb_out", int'(rgb_out), int'(last_rgb));
      chk("sprite_hit", int'(sprite_hit), int'(last_hit));
      if (rgb_valid && sprite_hit) hit_cnt++;
      if (eav[cidx]) last_addr = ea[cidx];
      chk("rom_addr", int'(rom_addr), int'(last_addr));
      ev[cidx]  = 1'b0;
      eav[cidx] = 1'b0;
    end
  end

  // Model: a hit is any qualifying pixel inside the latched rectangle
  // once a frame has started since reset.
  task automatic tick();
    int a, i1, i2;
    bit hit;
    logic [11:0] tex;
    i1 = (cyc + 1) % 64;
    i2 = (cyc + 2) % 64;
    if (rst && pixel_clk && active) begin
      hit = m_framed && m_sen &&
            int'(H) >= m_sx && int'(H) < m_sx + 32 &&
            int'(V) >= m_sy && int'(V) < m_sy + 32;
      ev[i2]  = 1'b1;
      erg[i2] = bg;
      eh[i2]  = 1'b0;
      if (hit) begin
        a = (int'(V) - m_sy) * 32 + (int'(H) - m_sx);
        eav[i1] = 1'b1;
        ea[i1]  = a[9:0];
        tex = rom[a];
        if (tex != 12'hF0F) begin
          erg[i2] = tex;
          eh[i2]  = 1'b1;
        end
      end
    end
    if (rst && frame_start) begin
      m_sx = int'(sxi);
      m_sy = int'(syi);
      m_sen = sprite_en_in;
      m_framed = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ev[i] = 1'b0;
      eav[i] = 1'b0;
    end
    last_rgb = '0;
    last_hit = 1'b0;
    last_addr = '0;
    m_sx = 0;
    m_sy = 0;
    m_sen = 1'b0;
    m_framed = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic frame(input int x, input int y, input bit en);
    sxi = 10'(x);
    syi = 10'(y);
    sprite_en_in = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic strobe(input int h, input int v);
    H = 10'(h);
    V = 10'(v);
    bg = 12'($urandom);
    pixel_clk = 1'b1;
    active = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    pixel_clk = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pix_lit(input int h, input int v, input logic [11:0] bgv,
                         input logic [11:0] er, input bit ehit,
                         input bit ca, input int eaddr);
    H = 10'(h);
    V = 10'(v);
    bg = bgv;
    pixel_clk = 1'b1;
    active = 1'b1;
    tick();
    pixel_clk = 1'b0;
    if (ca) chk("lit_rom_addr", int'(rom_addr), eaddr);
    tick();
    chk("lit_valid", int'(rgb_valid), 1);
    chk("lit_rgb", int'(rgb_out), int'(er));
    chk("lit_hit", int'(sprite_hit), int'(ehit));
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 12'($urandom);
    for (int i = 0; i < 1024; i += 9) rom[i] = 12'hF0F;
    for (int i = 0; i < 64; i++)
      if (rom[i] == 12'hF0F) rom[i] = 12'h000;
    rom[0]    = 12'h0F0;
    rom[5]    = 12'hF0F;
    rom[1023] = 12'h123;

    do_reset();
    tick();
    chk("reset_rgb_valid", int'(rgb_valid), 0);
    chk("reset_rgb_out", int'(rgb_out), 0);

    pix_lit(100, 10, 12'hABC, 12'hABC, 1'b0, 1'b0, 0);

    frame(100, 50, 1'b1);
    pix_lit(100, 50, 12'h111, 12'h0F0, 1'b1, 1'b1, 0);
    sxi = 10'd300;
    pix_lit(100, 50, 12'h555, 12'h0F0, 1'b1, 1'b1, 0);
    pix_lit(105, 50, 12'h444, 12'h444, 1'b0, 1'b1, 5);
    pix_lit(131, 81, 12'h222, 12'h123, 1'b1, 1'b1, 1023);
    pix_lit(132, 81, 12'h333, 12'h333, 1'b0, 1'b0, 0);

    frame(620, 20, 1'b1);
    idle(2);
    h0 = hit_cnt;
    for (int h = 619; h < 640; h++) strobe(h, 21);
    for (int h = 0; h < 12; h++) strobe(h, 22);
    idle(4);
    chk("clip_hits", hit_cnt - h0, 20);

    frame(700, 20, 1'b1);
    idle(2);
    h0 = hit_cnt;
    for (int h = 600; h < 640; h++) strobe(h, 21);
    for (int h = 0; h < 12; h++) strobe(h, 22);
    idle(4);
    chk("offscreen_hits", hit_cnt - h0, 0);

    frame(100, 50, 1'b1);
    for (int h = 100; h < 106; h++) strobe(h, 50);
    pixel_clk = 1'b1;
    do_reset();
    h0 = hit_cnt;
    for (int h = 107; h < 120; h++) strobe(h, 50);
    idle(4);
    chk("post_reset_hits", hit_cnt - h0, 0);
    pix_lit(100, 50, 12'h777, 12'h777, 1'b0, 1'b0, 0);
    frame(100, 50, 1'b1);
    pix_lit(100, 50, 12'h888, 12'h0F0, 1'b1, 1'b1, 0);

    for (int f = 0; f < 12; f++) begin
      rx = $urandom_range(0, 720);
      ry = $urandom_range(0, 500);
      ren = ($urandom_range(0, 4) != 0);
      if (f % 3 == 0) begin
        H = 10'($urandom_range(0, 639));
        V = 10'd479;
        pixel_clk = 1'b1;
        active = 1'b1;
      end else begin
        pixel_clk = 1'b0;
      end
      frame(rx, ry, ren);
      pixel_clk = 1'b0;
      rv = (ry > 3) ? ry - 3 : 0;
      rhs = (rx > 3) ? rx - 3 : 0;
      if (rhs > 600) rhs = 600;
      for (int r = 0; r < 6; r++) begin
        if (rv > 479) break;
        for (int h = rhs; h < rhs + 40; h++) begin
          H = 10'(h);
          V = 10'(rv);
          bg = 12'($urandom);
          pixel_clk = ($urandom_range(0, 3) != 0);
          active = ($urandom_range(0, 7) != 0);
          sxi = 10'($urandom_range(0, 639));
          syi = 10'($urandom_range(0, 479));
          tick();
        end
        rv += $urandom_range(1, 9);
      end
      idle(1);
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
